softmax_stream: RTL and testbench
=================================

// Module: softmax_stream
// PURPOSE
//  Parametrised streaming online-softmax numerator/denominator engine, LANES independent lanes.
//  Per row: tracks running max m, emits y = exp2(x - m) per accepted beat with m, then the
//  rescaled denominator. Sits after the QK^T score path; a downstream divider normalises.
//  Successor to the fixed 16-lane block: adds valid/ready input, generic row length/widths, masking.
// PARAMETERS
//  LANES    16  parallel lanes (rows processed side by side)
//  ROW_LEN  16  beats per row (>=2)
//  IN_W     40  signed logit width, log2 domain (x*log2e already applied upstream)
//  XF        4  fraction bits of logit (XF <= Y_W-1)
//  Y_W       8  y width, unsigned Q1.(Y_W-1)
//  D_W      localparam Y_W+$clog2(ROW_LEN); denom unsigned, Y_W-1 frac bits
// PORTS
//  i_clk      in   1           clock, rising edge
//  i_rst      in   1           synchronous, active-high reset
//  i_start    in   1           begin row; sampled only in IDLE
//  i_valid    in   1           input beat valid
//  o_ready    out  1           high in RUN; beat accepted on i_valid&o_ready
//  i_data     in   LANES*IN_W  lane k logit at [k*IN_W +: IN_W]
//  i_mask     in   LANES       (SOFTMAX_MASK_EN only) 1 = exclude element
//  o_y        out  LANES*Y_W   exp2(x-m), Q1.(Y_W-1)
//  o_runmax   out  LANES*IN_W  running max including this beat
//  o_y_valid  out  1           one pulse per accepted beat, no backpressure
//  o_denom    out  LANES*D_W   final sum, referenced to final max
//  o_denom_valid out 1         one-cycle pulse per row
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lane max = most-negative, denom 0, seen flags 0.
//  FSM: IDLE -i_start-> RUN (clear max/denom/seen, beat cnt 0); RUN -ROW_LEN-th accept-> DRAIN;
//   DRAIN (2 cycles, pipe empties) -> DONE; DONE pulses o_denom_valid, -> IDLE next cycle.
//  i_start outside IDLE ignored. Gaps in i_valid allowed; counter advances on accept only.
//  Pipe: S1 (accept+1) m_new = seen ? max(m_old,x) : x; a_y = m_new-x; a_s = m_new-m_old.
//   S2 (accept+2) y, denom update; o_y/o_runmax/o_y_valid registered: latency 2 cycles.
//  exp2(-a), a>=0 in Q.XF: n = a>>XF, r = a[XF-1:0]; M = 2^Y_W - (r<<(Y_W-1-XF));
//   result = M >> (n+1), truncating; 0 if n+1 > Y_W. a=0 gives exactly 2^(Y_W-1) (1.0).
//  Scale s = seen_old ? exp2(-a_s) : 0. denom = ((denom*s) >> (Y_W-1)) + y, saturate at 2^D_W-1.
//  o_denom valid 1 cycle after last o_y_valid; holds until next row's start clears it.
//  Subtraction done in IN_W+1 bits; a saturates to all-ones when >= 2^(IN_W) (never wraps).
//  Reset mid-row: immediate IDLE, outputs 0, no denom pulse.
// CONFIGURATION
//  SOFTMAX_MASK_EN defined: i_mask present; masked lane element -> y=0, m and denom unchanged,
//   seen unchanged; o_runmax shows unchanged m. Fully masked lane ends row with m=most-negative, denom 0.
//  Undefined: no i_mask port; every element participates.
// STRUCTURE
//  softmax_pkg: state enum (IDLE/RUN/DRAIN/DONE), default width constants, exp2 helper widths.
//  Sub-module softmax_exp2 (combinational exp2(-a) per above), two instances per lane (y, scale).
// TESTING (XF=4, Y_W=8, D_W=12, ROW_LEN=16, all lanes same unless noted)
//  1 x=0 all beats -> every y=128, runmax=0, denom=2048.
//  2 beat k x=16k -> every y=128, runmax=16k; denom sequence 128,192,224,...,255; final 255.
//  3 beat k x=-16k -> runmax=0, y=128>>k (0 for k>=8), final denom=255.
//  4 x0=0, x1=-8, rest x=-4096 -> y1=96, y>=2: 0, denom=224.
//  5 i_valid gaps, i_start mid-row, reset at beat 7 -> only accepted beats emitted, start
//    ignored, after reset all outputs 0 and new row correct.
//  6 (SOFTMAX_MASK_EN) lane 3 masked beats 0..7, x=0 -> lane3 y=0 there, denom=1024; lane0 2048.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared FSM state type and default widths for the online-softmax engine.
package softmax_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DEF_LANES   = 16;
    localparam int DEF_ROW_LEN = 16;
    localparam int DEF_IN_W    = 40;
    localparam int DEF_XF      = 4;
    localparam int DEF_Y_W     = 8;
endpackage

// File: rtl/softmax_exp2.sv
// softmax_exp2: combinational exp2(-a) for unsigned a in Q.XF, result unsigned Q1.(Y_W-1).
module softmax_exp2
    import softmax_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int XF   = DEF_XF,
    parameter int Y_W  = DEF_Y_W
) (
    input  logic [IN_W-1:0] i_a,
    output logic [Y_W-1:0]  o_e
);
    logic [IN_W-XF-1:0] w_n;
    logic [Y_W:0]       w_m;
    logic [Y_W-1:0]     w_sh;
    assign w_n  = i_a[IN_W-1:XF];
    // Linear interpolation of the fractional part: 2^-r ~ 1 - r/2 over [0,1)
    assign w_m  = (Y_W+1)'(1 << Y_W) - ((Y_W+1)'(i_a[XF-1:0]) << (Y_W-1-XF));
    assign w_sh = Y_W'((w_m >> 1) >> w_n);
    assign o_e  = (w_n >= (IN_W-XF)'(Y_W)) ? '0 : w_sh;
endmodule

// File: rtl/softmax_stream.sv
// softmax_stream: streaming online-softmax numerator/denominator engine over LANES lanes.
// Defining SOFTMAX_MASK_EN adds the i_mask port for per-element exclusion.
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int  LANES   = DEF_LANES,
    parameter int  ROW_LEN = DEF_ROW_LEN,
    parameter int  IN_W    = DEF_IN_W,
    parameter int  XF      = DEF_XF,
    parameter int  Y_W     = DEF_Y_W,
    localparam int D_W     = Y_W + $clog2(ROW_LEN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [LANES*IN_W-1:0] i_data,
`ifdef SOFTMAX_MASK_EN
    input  logic [LANES-1:0]      i_mask,
`endif
    output logic [LANES*Y_W-1:0]  o_y,
    output logic [LANES*IN_W-1:0] o_runmax,
    output logic                  o_y_valid,
    output logic [LANES*D_W-1:0]  o_denom,
    output logic                  o_denom_valid
);
    localparam int CW = $clog2(ROW_LEN);
    localparam logic [IN_W-1:0] M_NEG = {1'b1, {(IN_W-1){1'b0}}};
    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_drain, r_s1_v, r_y_valid;
    logic            w_start, w_acc, w_last;
    logic [LANES-1:0] w_mask;
`ifdef SOFTMAX_MASK_EN
    assign w_mask = i_mask;
`else
    assign w_mask = '0;
`endif
    assign w_start       = (r_state == IDLE) && i_start;
    assign w_acc         = (r_state == RUN) && i_valid;
    assign w_last        = w_acc && (r_cnt == CW'(ROW_LEN-1));
    assign o_ready       = r_state == RUN;
    assign o_denom_valid = r_state == DONE;
    assign o_y_valid     = r_y_valid;
    always_comb begin
        w_next = w_start ? RUN :
                 w_last ? DRAIN :
                 (r_state == DRAIN && r_drain) ? DONE :
                 (r_state == DONE) ? IDLE : r_state;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            r_s1_v    <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_start ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
            r_drain   <= (r_state == DRAIN) && !r_drain;
            r_s1_v    <= w_acc;
            r_y_valid <= r_s1_v;
        end
    end
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [IN_W-1:0] w_x, w_mnew, r_max;
        logic [IN_W:0]          w_dy, w_ds;
        logic [IN_W-1:0]        r_a_y, r_a_s, r_runmax;
        logic                   r_seen, r_sold, r_msk;
        logic [Y_W-1:0]         w_ey, w_es, w_s, w_y, r_y;
        logic [D_W+Y_W-1:0]     w_prod;
        logic [D_W+1:0]         w_sum;
        logic [D_W-1:0]         r_denom;
        assign w_x    = i_data[k*IN_W +: IN_W];
        assign w_mnew = (r_seen && r_max > w_x) ? r_max : w_x;
        // Differences are non-negative by construction; one extra bit covers the full span
        assign w_dy   = {w_mnew[IN_W-1], w_mnew} - {w_x[IN_W-1], w_x};
        assign w_ds   = {w_mnew[IN_W-1], w_mnew} - {r_max[IN_W-1], r_max};
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_max  <= M_NEG;
                r_seen <= 1'b0;
                r_a_y  <= '0;
                r_a_s  <= '0;
                r_sold <= 1'b0;
                r_msk  <= 1'b0;
            end else if (w_start) begin
                r_max  <= M_NEG;
                r_seen <= 1'b0;
            end else if (w_acc) begin
                r_a_y  <= w_dy[IN_W] ? '1 : w_dy[IN_W-1:0];
                r_a_s  <= w_ds[IN_W] ? '1 : w_ds[IN_W-1:0];
                r_sold <= r_seen;
                r_msk  <= w_mask[k];
                if (!w_mask[k]) begin
                    r_max  <= w_mnew;
                    r_seen <= 1'b1;
                end
            end
        end
        softmax_exp2 #(.IN_W(IN_W), .XF(XF), .Y_W(Y_W)) u_exp_y (.i_a(r_a_y), .o_e(w_ey));
        softmax_exp2 #(.IN_W(IN_W), .XF(XF), .Y_W(Y_W)) u_exp_s (.i_a(r_a_s), .o_e(w_es));
        assign w_s    = r_sold ? w_es : '0;
        assign w_y    = r_msk ? '0 : w_ey;
        assign w_prod = (D_W+Y_W)'(r_denom) * (D_W+Y_W)'(w_s);
        assign w_sum  = (D_W+2)'(w_prod >> (Y_W-1)) + (D_W+2)'(w_y);
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_y      <= '0;
                r_runmax <= '0;
                r_denom  <= '0;
            end else if (w_start) begin
                r_denom  <= '0;
            end else if (r_s1_v) begin
                r_y      <= w_y;
                r_runmax <= r_max;
                if (!r_msk) r_denom <= |w_sum[D_W+1:D_W] ? '1 : w_sum[D_W-1:0];
            end
        end
        assign o_y[k*Y_W +: Y_W]       = r_y;
        assign o_runmax[k*IN_W +: IN_W] = r_runmax;
        assign o_denom[k*D_W +: D_W]    = r_denom;
    end
endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: scoreboard bench for softmax_stream with a behavioural softmax model.
module tb_softmax_stream;
    localparam int LANES = 16, ROW_LEN = 16, IN_W = 40, XF = 4, Y_W = 8;
    localparam int D_W = Y_W + $clog2(ROW_LEN);
    localparam int XW = LANES*IN_W, YW = LANES*Y_W, DW = LANES*D_W;
    typedef struct {
        logic [YW-1:0] y;
        logic [XW-1:0] rm;
        logic [DW-1:0] d;
    } beat_t;

    logic i_clk = 0, i_rst = 1, i_start = 0, i_valid = 0;
    logic [XW-1:0]    i_data = '0;
    logic [LANES-1:0] i_mask = '0;
    logic             o_ready, o_y_valid, o_denom_valid;
    logic [YW-1:0]    o_y;
    logic [XW-1:0]    o_runmax;
    logic [DW-1:0]    o_denom;
    int     checks = 0, errors = 0;
    beat_t  q_beat[$];
    logic [DW-1:0] q_den[$];
    longint m_ref[LANES];
    bit     seen_ref[LANES];
    int     d_ref[LANES];
    logic   prev_yv = 0;
    beat_t  mon_e;

    always #5 i_clk = ~i_clk;

    softmax_stream #(.LANES(LANES), .ROW_LEN(ROW_LEN), .IN_W(IN_W), .XF(XF), .Y_W(Y_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data),
`ifdef SOFTMAX_MASK_EN
        .i_mask(i_mask),
`endif
        .o_y(o_y), .o_runmax(o_runmax), .o_y_valid(o_y_valid),
        .o_denom(o_denom), .o_denom_valid(o_denom_valid)
    );

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // exp2(-a) in the log2 domain: integer part shifts, fractional part interpolated linearly
    function automatic int ex2(input longint a);
        longint n = a >>> XF;
        int     r = int'(a & ((1 << XF) - 1));
        if (n + 1 > Y_W) return 0;
        return ((1 << Y_W) - r * (1 << (Y_W - 1 - XF))) >> (n + 1);
    endfunction

    function automatic beat_t model_beat(input logic [XW-1:0] x, input logic [LANES-1:0] msk);
        beat_t e;
        for (int k = 0; k < LANES; k++) begin
            longint xv = longint'($signed(x[k*IN_W +: IN_W]));
            longint mn;
            int     y = 0;
            if (!msk[k]) begin
                mn = (seen_ref[k] && m_ref[k] > xv) ? m_ref[k] : xv;
                y  = ex2(mn - xv);
                d_ref[k] = ((d_ref[k] * (seen_ref[k] ? ex2(mn - m_ref[k]) : 0)) >> (Y_W - 1)) + y;
                if (d_ref[k] > (1 << D_W) - 1) d_ref[k] = (1 << D_W) - 1;
                m_ref[k]    = mn;
                seen_ref[k] = 1;
            end
            e.y[k*Y_W +: Y_W]   = Y_W'(y);
            e.rm[k*IN_W +: IN_W] = IN_W'(m_ref[k]);
            e.d[k*D_W +: D_W]    = D_W'(d_ref[k]);
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] repd(input int c);
        logic [DW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*D_W +: D_W] = D_W'(c);
        return v;
    endfunction

    function automatic logic [IN_W-1:0] gen(input int mode, input int b);
        logic [63:0] w;
        w = {$urandom, $urandom};
        case (mode)
            1: return IN_W'(16 * b);
            2: return IN_W'(-16 * b);
            3: return IN_W'(b == 0 ? 0 : b == 1 ? -8 : -4096);
            4: return IN_W'(int'($urandom_range(0, 1023)) - 512);
            5: return w[IN_W-1:0];
            6: return IN_W'(8 * b + int'($urandom_range(0, 63)));
            default: return '0;
        endcase
    endfunction

    function automatic logic [LANES-1:0] gen_mask(input int mode, input int b);
`ifdef SOFTMAX_MASK_EN
        if (mode == 7) return b < 8 ? LANES'(8) : '0;
        if (mode >= 4) return LANES'($urandom) & LANES'($urandom);
`endif
        return (mode < 0 || b < 0) ? '1 : '0;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_row();
        i_start = 1;
        tick();
        i_start = 0;
        for (int k = 0; k < LANES; k++) begin
            m_ref[k] = -(longint'(1) << (IN_W - 1));
            seen_ref[k] = 0;
            d_ref[k] = 0;
        end
        chk("ready_after_start", XW'(o_ready), XW'(1));
    endtask

    task automatic beat(input logic [XW-1:0] x, input logic [LANES-1:0] msk, input int gap,
                        input logic st, input bit last);
        repeat (gap) tick();
        i_data = x; i_mask = msk; i_valid = 1; i_start = st;
        chk("ready", XW'(o_ready), XW'(1));
        q_beat.push_back(model_beat(x, msk));
        if (last) q_den.push_back(q_beat[$].d);
        tick();
        i_valid = 0; i_start = 0;
    endtask

    task automatic end_row();
        int t = 0;
        while (!o_denom_valid && t < 8) begin
            tick();
            t++;
        end
        chk("denom_pulse", XW'(o_denom_valid), XW'(1));
        tick();
        chk("idle_after_done", XW'({o_denom_valid, o_ready}), '0);
    endtask

    task automatic run_row(input int mode, input int gap_pct);
        logic [XW-1:0] x;
        start_row();
        for (int b = 0; b < ROW_LEN; b++) begin
            for (int k = 0; k < LANES; k++) x[k*IN_W +: IN_W] = gen(mode, b);
            beat(x, gen_mask(mode, b),
                 ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0, 0, b == ROW_LEN - 1);
        end
        end_row();
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_y_valid) begin
                if (q_beat.size() == 0) chk("y_unexpected", XW'(o_y_valid), '0);
                else begin
                    mon_e = q_beat.pop_front();
                    chk("y", XW'(o_y), XW'(mon_e.y));
                    chk("runmax", o_runmax, mon_e.rm);
                    chk("denom_running", XW'(o_denom), XW'(mon_e.d));
                end
            end
            if (o_denom_valid) begin
                chk("denom_after_last_y", XW'(prev_yv), XW'(1));
                if (q_den.size() == 0) chk("denom_unexpected", XW'(o_denom_valid), '0);
                else chk("denom", XW'(o_denom), XW'(q_den.pop_front()));
            end
            prev_yv = o_y_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [XW-1:0] x;
        repeat (3) tick();
        i_rst = 0;
        chk("reset_ctl", XW'({o_y, o_y_valid, o_denom_valid, o_ready}), '0);
        chk("reset_runmax", o_runmax, '0);
        chk("reset_denom", XW'(o_denom), '0);
        tick();
        run_row(0, 0);
        chk("t1_denom", XW'(o_denom), XW'(repd(2048)));
        run_row(1, 0);
        chk("t2_denom", XW'(o_denom), XW'(repd(255)));
        run_row(2, 0);
        chk("t3_denom", XW'(o_denom), XW'(repd(255)));
        run_row(3, 0);
        chk("t4_denom", XW'(o_denom), XW'(repd(224)));
        start_row();
        for (int b = 0; b < 7; b++) begin
            for (int k = 0; k < LANES; k++) x[k*IN_W +: IN_W] = gen(4, b);
            beat(x, '0, (b % 2 == 1) ? 2 : 0, (b == 2 || b == 3) ? 1'b1 : 1'b0, 0);
        end
        repeat (4) tick();
        chk("drained_before_rst", XW'(q_beat.size()), '0);
        i_rst = 1;
        tick();
        i_rst = 0;
        chk("rst_midrow_ctl", XW'({o_y, o_y_valid, o_denom_valid, o_ready}), '0);
        chk("rst_midrow_runmax", o_runmax, '0);
        chk("rst_midrow_denom", XW'(o_denom), '0);
        repeat (3) tick();
        run_row(4, 30);
        for (int i = 0; i < 6; i++) run_row(4 + i % 3, 30);
`ifdef SOFTMAX_MASK_EN
        run_row(7, 0);
        chk("t6_lane3_denom", XW'(o_denom[3*D_W +: D_W]), XW'(1024));
        chk("t6_lane0_denom", XW'(o_denom[0 +: D_W]), XW'(2048));
`endif
        repeat (4) tick();
        chk("beat_queue_drained", XW'(q_beat.size()), '0);
        chk("denom_queue_drained", XW'(q_den.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
